// File: rtl/hood_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hood_pkg
// Description : Shared types and helpers for the range-hood fan controller.
//               Holds the controller state encoding and the turbo level code.
// Revision    : 1.0 - initial release
// ============================================================================
package hood_pkg;

    // Controller state encoding; the values are visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_TURBO = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // Turbo is reported as the level one above the highest normal level.
    function automatic int unsigned turbo_level_code(input int unsigned num_levels);
        return num_levels + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hood_fan_ctrl_sec_countdown.sv
`default_nettype none
// ============================================================================
// Module      : sec_countdown
// Description : Loadable seconds down-counter. Decrements on each tick and
//               stops at zero. done pulses on a tick seen while count is 1.
//               A load in the same cycle as a tick takes precedence.
// Revision    : 1.0 - initial release
// ============================================================================
module sec_countdown #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: load wins over tick, and zero is sticky so there is no underflow.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - C_ONE;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = tick && (count_q == C_ONE);

endmodule
`default_nettype wire

// File: rtl/hood_fan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hood_fan_ctrl
// Description : Range-hood fan controller. Selects one of NUM_LEVELS normal
//               speeds, a timed once-per-session turbo, and a timed low-speed
//               drain after leaving turbo. Tracks saturating fan runtime.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module hood_fan_ctrl
    import hood_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int TURBO_SECS = 60,
    parameter int DRAIN_SECS = 60,
    parameter int CNT_W      = 8,
    parameter int RUNTIME_W  = 20,
    parameter int LW         = $clog2(NUM_LEVELS + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_1hz,
    input  logic                 menu_key,
    input  logic                 level_key,
    input  logic [LW-1:0]        level_sel,
    input  logic                 turbo_key,
    output logic [LW-1:0]        fan_level,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     countdown,
    output logic [RUNTIME_W-1:0] runtime,
    output logic                 busy,
    output logic                 turbo_avail
);

    localparam logic [LW-1:0]        C_LVL_OFF   = '0;
    localparam logic [LW-1:0]        C_LVL_LOW   = LW'(1);
    localparam logic [LW-1:0]        C_LVL_MAX   = LW'(NUM_LEVELS);
    localparam logic [LW-1:0]        C_LVL_TURBO = LW'(turbo_level_code(NUM_LEVELS));
    localparam logic [CNT_W-1:0]     C_TURBO_LD  = CNT_W'(TURBO_SECS);
    localparam logic [CNT_W-1:0]     C_DRAIN_LD  = CNT_W'(DRAIN_SECS);
    localparam logic [RUNTIME_W-1:0] C_RT_MAX    = '1;
    localparam logic [RUNTIME_W-1:0] C_RT_ONE    = RUNTIME_W'(1);

    state_e               state_d,   state_q;
    logic [LW-1:0]        level_d,   level_q;
    logic                 busy_d,    busy_q;
    logic                 avail_d,   avail_q;
    logic [RUNTIME_W-1:0] runtime_d, runtime_q;

    logic                 w_valid_sel;
    logic                 w_cnt_load;
    logic [CNT_W-1:0]     w_cnt_load_val;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_cnt_done;

    assign w_valid_sel = (level_sel != C_LVL_OFF) && (level_sel <= C_LVL_MAX);

    // One timer serves both turbo and drain; it only runs in those states
    // and naturally rests at zero everywhere else.
    sec_countdown #(
        .CNT_W (CNT_W)
    ) u_sec_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .tick     (tick_1hz),
        .count    (w_cnt),
        .done     (w_cnt_done)
    );

    // Next-state and level selection; key priority is menu, then turbo, then level.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        avail_d        = avail_q;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (turbo_key && avail_q) begin
                    state_d        = ST_TURBO;
                    level_d        = C_LVL_TURBO;
                    avail_d        = 1'b0;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = C_TURBO_LD;
                end else if (level_key && w_valid_sel) begin
                    state_d = ST_RUN;
                    level_d = level_sel;
                end
            end
            ST_RUN: begin
                if (menu_key) begin
                    state_d = ST_IDLE;
                    level_d = C_LVL_OFF;
                    avail_d = 1'b1;
                end else if (turbo_key && avail_q) begin
                    state_d        = ST_TURBO;
                    level_d        = C_LVL_TURBO;
                    avail_d        = 1'b0;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = C_TURBO_LD;
                end else if (level_key && w_valid_sel) begin
                    level_d = level_sel;
                end
            end
            ST_TURBO: begin
                if (menu_key) begin
                    state_d        = ST_DRAIN;
                    level_d        = C_LVL_LOW;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = C_DRAIN_LD;
                end else if (w_cnt_done) begin
                    state_d = ST_RUN;
                    level_d = C_LVL_MAX;
                end
            end
            ST_DRAIN: begin
                if (w_cnt_done) begin
                    state_d = ST_IDLE;
                    level_d = C_LVL_OFF;
                    avail_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = C_LVL_OFF;
                avail_d = 1'b1;
            end
        endcase

        busy_d = (level_d != C_LVL_OFF);
    end

    // Runtime counts ticks while the fan is spinning and holds at full scale.
    always_comb begin
        runtime_d = runtime_q;
        if (tick_1hz && (level_q != C_LVL_OFF) && (runtime_q != C_RT_MAX)) begin
            runtime_d = runtime_q + C_RT_ONE;
        end
    end

    // Controller registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            level_q   <= C_LVL_OFF;
            busy_q    <= 1'b0;
            avail_q   <= 1'b1;
            runtime_q <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            busy_q    <= busy_d;
            avail_q   <= avail_d;
            runtime_q <= runtime_d;
        end
    end

    assign state       = state_q;
    assign fan_level   = level_q;
    assign countdown   = w_cnt;
    assign runtime     = runtime_q;
    assign busy        = busy_q;
    assign turbo_avail = avail_q;

endmodule
`default_nettype wire

// File: tb/tb_hood_fan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hood_fan_ctrl
// Description : Self-checking bench for hood_fan_ctrl. Directed scenarios
//               plus randomized keys checked against a behavioural model.
//               A second instance with a 4-bit runtime shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hood_fan_ctrl;

    localparam int N  = 3;
    localparam int TS = 60;
    localparam int DS = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       menu_key = 1'b0;
    logic       level_key = 1'b0;
    logic [2:0] level_sel = 3'd0;
    logic       turbo_key = 1'b0;

    logic [2:0]  fan_level;
    logic [1:0]  state;
    logic [7:0]  countdown;
    logic [19:0] runtime;
    logic        busy;
    logic        turbo_avail;

    logic [2:0]  s_fan_level;
    logic [1:0]  s_state;
    logic [7:0]  s_countdown;
    logic [3:0]  s_runtime;
    logic        s_busy;
    logic        s_turbo_avail;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hood_fan_ctrl u_dut (
        .clk (clk), .rst (rst), .tick_1hz (tick_1hz), .menu_key (menu_key),
        .level_key (level_key), .level_sel (level_sel), .turbo_key (turbo_key),
        .fan_level (fan_level), .state (state), .countdown (countdown),
        .runtime (runtime), .busy (busy), .turbo_avail (turbo_avail)
    );

    hood_fan_ctrl #(.RUNTIME_W(4)) u_dut_sat (
        .clk (clk), .rst (rst), .tick_1hz (tick_1hz), .menu_key (menu_key),
        .level_key (level_key), .level_sel (level_sel), .turbo_key (turbo_key),
        .fan_level (s_fan_level), .state (s_state), .countdown (s_countdown),
        .runtime (s_runtime), .busy (s_busy), .turbo_avail (s_turbo_avail)
    );

    // One clock with the given inputs held across the edge; returns 1 ns after it.
    task automatic cyc(input bit m, input bit t, input bit l, input logic [2:0] s, input bit tk);
        menu_key = m; turbo_key = t; level_key = l; level_sel = s; tick_1hz = tk;
        @(posedge clk); #1;
        menu_key = 0; turbo_key = 0; level_key = 0; tick_1hz = 0;
    endtask

    task automatic do_reset();
        menu_key = 0; turbo_key = 0; level_key = 0; tick_1hz = 0; level_sel = 0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (fan_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fan_level); end
        checks++; if (countdown !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", countdown); end
        checks++; if (runtime !== 20'd0) begin errors++; $display("FAIL reset_runtime got=%0d exp=0", runtime); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (turbo_avail !== 1'b1) begin errors++; $display("FAIL reset_avail got=%0b exp=1", turbo_avail); end
    endtask

    task automatic test_level_run();
        do_reset();
        cyc(0, 0, 1, 3'd2, 0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_state got=%0d exp=1", state); end
        checks++; if (fan_level !== 3'd2) begin errors++; $display("FAIL run_level got=%0d exp=2", fan_level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got=%0b exp=1", busy); end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 3'd0, 1);
        checks++; if (runtime !== 20'd5) begin errors++; $display("FAIL run_runtime got=%0d exp=5", runtime); end
        cyc(0, 0, 1, 3'd2, 0);
        checks++; if (fan_level !== 3'd2 || state !== 2'd1) begin errors++; $display("FAIL run_same_level got=%0d/%0d exp=2/1", fan_level, state); end
    endtask

    task automatic test_turbo_timeout();
        do_reset();
        cyc(0, 1, 0, 3'd0, 0);
        checks++; if (state !== 2'd2 || fan_level !== 3'd4 || countdown !== 8'(TS) || turbo_avail !== 1'b0)
            begin errors++; $display("FAIL turbo_entry got st=%0d lvl=%0d cnt=%0d av=%0b exp 2/4/%0d/0", state, fan_level, countdown, turbo_avail, TS); end
        for (int i = 1; i < TS; i++) begin
            cyc(0, 0, 0, 3'd0, 1);
            checks++; if (countdown !== 8'(TS - i) || state !== 2'd2)
                begin errors++; $display("FAIL turbo_count tick=%0d got=%0d/%0d exp=%0d/2", i, countdown, state, TS - i); end
        end
        cyc(0, 0, 0, 3'd0, 1);
        checks++; if (state !== 2'd1 || fan_level !== 3'(N) || countdown !== 8'd0 || turbo_avail !== 1'b0)
            begin errors++; $display("FAIL turbo_timeout got st=%0d lvl=%0d cnt=%0d av=%0b exp 1/%0d/0/0", state, fan_level, countdown, turbo_avail, N); end
        checks++; if (runtime !== 20'(TS)) begin errors++; $display("FAIL turbo_runtime got=%0d exp=%0d", runtime, TS); end
        cyc(0, 1, 0, 3'd0, 0);
        checks++; if (state !== 2'd1 || countdown !== 8'd0) begin errors++; $display("FAIL turbo_reuse got=%0d/%0d exp=1/0", state, countdown); end
    endtask

    task automatic test_drain();
        do_reset();
        cyc(0, 1, 0, 3'd0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 3'd0, 1);
        checks++; if (countdown !== 8'd40) begin errors++; $display("FAIL drain_pre got=%0d exp=40", countdown); end
        cyc(1, 0, 0, 3'd0, 0);
        checks++; if (state !== 2'd3 || fan_level !== 3'd1 || countdown !== 8'(DS) || busy !== 1'b1)
            begin errors++; $display("FAIL drain_entry got st=%0d lvl=%0d cnt=%0d busy=%0b exp 3/1/%0d/1", state, fan_level, countdown, busy, DS); end
        cyc(0, 0, 1, 3'd2, 0);
        cyc(0, 1, 0, 3'd0, 0);
        cyc(1, 0, 0, 3'd0, 0);
        checks++; if (state !== 2'd3 || fan_level !== 3'd1 || countdown !== 8'(DS))
            begin errors++; $display("FAIL drain_keys got st=%0d lvl=%0d cnt=%0d exp 3/1/%0d", state, fan_level, countdown, DS); end
        for (int i = 1; i < DS; i++) cyc(0, 0, 0, 3'd0, 1);
        checks++; if (state !== 2'd3 || countdown !== 8'd1) begin errors++; $display("FAIL drain_last got=%0d/%0d exp=3/1", state, countdown); end
        cyc(0, 0, 0, 3'd0, 1);
        checks++; if (state !== 2'd0 || fan_level !== 3'd0 || turbo_avail !== 1'b1 || busy !== 1'b0 || countdown !== 8'd0)
            begin errors++; $display("FAIL drain_done got st=%0d lvl=%0d av=%0b busy=%0b cnt=%0d exp 0/0/1/0/0", state, fan_level, turbo_avail, busy, countdown); end
    endtask

    task automatic test_same_cycle();
        logic [19:0] rt0;
        do_reset();
        cyc(0, 0, 1, 3'd1, 0);
        cyc(1, 1, 1, 3'd2, 0);
        checks++; if (state !== 2'd0 || fan_level !== 3'd0 || turbo_avail !== 1'b1)
            begin errors++; $display("FAIL prio_menu got st=%0d lvl=%0d av=%0b exp 0/0/1", state, fan_level, turbo_avail); end
        cyc(0, 0, 1, 3'd2, 0);
        cyc(0, 0, 0, 3'd0, 1);
        rt0 = runtime;
        cyc(0, 1, 0, 3'd0, 1);
        checks++; if (state !== 2'd2 || countdown !== 8'(TS)) begin errors++; $display("FAIL tick_load got=%0d/%0d exp=2/%0d", state, countdown, TS); end
        checks++; if (runtime !== rt0 + 20'd1) begin errors++; $display("FAIL tick_runtime got=%0d exp=%0d", runtime, rt0 + 20'd1); end
        cyc(0, 0, 1, 3'd1, 1);
        checks++; if (state !== 2'd2 || fan_level !== 3'd4 || countdown !== 8'(TS - 1))
            begin errors++; $display("FAIL turbo_lvlkey got st=%0d lvl=%0d cnt=%0d exp 2/4/%0d", state, fan_level, countdown, TS - 1); end
    endtask

    task automatic test_invalid_sel();
        do_reset();
        cyc(0, 0, 1, 3'd0, 0);
        checks++; if (state !== 2'd0 || fan_level !== 3'd0) begin errors++; $display("FAIL sel_zero got=%0d/%0d exp=0/0", state, fan_level); end
        cyc(0, 0, 1, 3'(N + 1), 0);
        checks++; if (state !== 2'd0 || fan_level !== 3'd0) begin errors++; $display("FAIL sel_over got=%0d/%0d exp=0/0", state, fan_level); end
        cyc(0, 0, 1, 3'd3, 0);
        cyc(0, 0, 1, 3'd7, 0);
        checks++; if (state !== 2'd1 || fan_level !== 3'd3) begin errors++; $display("FAIL sel_run_bad got=%0d/%0d exp=1/3", state, fan_level); end
    endtask

    task automatic test_saturation();
        do_reset();
        cyc(0, 0, 1, 3'd3, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 3'd0, 1);
        checks++; if (s_runtime !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", s_runtime); end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 3'd0, 1);
        checks++; if (s_runtime !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", s_runtime); end
        checks++; if (runtime !== 20'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", runtime); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(0, 1, 0, 3'd0, 0);
        cyc(1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 3'd0, 1);
        checks++; if (state !== 2'd3 || countdown !== 8'd30) begin errors++; $display("FAIL ar_pre got=%0d/%0d exp=3/30", state, countdown); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || fan_level !== 3'd0 || countdown !== 8'd0 || runtime !== 20'd0 || busy !== 1'b0 || turbo_avail !== 1'b1)
            begin errors++; $display("FAIL async_reset got st=%0d lvl=%0d cnt=%0d rt=%0d busy=%0b av=%0b exp 0/0/0/0/0/1", state, fan_level, countdown, runtime, busy, turbo_avail); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Randomized single-key traffic against a behavioural model of the controller.
    task automatic test_random();
        int m_state, m_level, m_cnt, m_avail, m_rt, m_rt4;
        int ns, nl, nc, na, k, sel;
        bit m, t, l, tk, valid;
        do_reset();
        m_state = 0; m_level = 0; m_cnt = 0; m_avail = 1; m_rt = 0; m_rt4 = 0;
        for (int c = 0; c < 3000; c++) begin
            k   = int'($urandom_range(0, 15));
            m   = (k == 0);
            t   = (k == 1);
            l   = (k >= 2 && k <= 4);
            sel = int'($urandom_range(0, 7));
            tk  = ($urandom_range(0, 1) == 1);
            valid = (sel >= 1 && sel <= N);
            ns = m_state; nl = m_level; nc = m_cnt; na = m_avail;
            if (tk && m_level != 0) begin
                if (m_rt < (1 << 20) - 1) m_rt++;
                if (m_rt4 < 15) m_rt4++;
            end
            case (m_state)
                0: if (t && m_avail == 1) begin ns = 2; nl = N + 1; nc = TS; na = 0; end
                   else if (l && valid) begin ns = 1; nl = sel; end
                1: if (m) begin ns = 0; nl = 0; na = 1; end
                   else if (t && m_avail == 1) begin ns = 2; nl = N + 1; nc = TS; na = 0; end
                   else if (l && valid) nl = sel;
                2: if (m) begin ns = 3; nl = 1; nc = DS; end
                   else if (tk) begin
                       if (m_cnt == 1) begin ns = 1; nl = N; nc = 0; end
                       else nc = m_cnt - 1;
                   end
                default: if (tk) begin
                       if (m_cnt == 1) begin ns = 0; nl = 0; nc = 0; na = 1; end
                       else nc = m_cnt - 1;
                   end
            endcase
            m_state = ns; m_level = nl; m_cnt = nc; m_avail = na;
            cyc(m, t, l, 3'(sel), tk);
            checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, state, m_state); end
            checks++; if (fan_level !== 3'(m_level)) begin errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fan_level, m_level); end
            checks++; if (countdown !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, countdown, m_cnt); end
            checks++; if (runtime !== 20'(m_rt)) begin errors++; $display("FAIL rnd_runtime c=%0d got=%0d exp=%0d", c, runtime, m_rt); end
            checks++; if (busy !== (m_level != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_level != 0); end
            checks++; if (turbo_avail !== 1'(m_avail)) begin errors++; $display("FAIL rnd_avail c=%0d got=%0b exp=%0d", c, turbo_avail, m_avail); end
            checks++; if (s_runtime !== 4'(m_rt4)) begin errors++; $display("FAIL rnd_rt4 c=%0d got=%0d exp=%0d", c, s_runtime, m_rt4); end
            checks++; if (s_state !== 2'(m_state) || s_fan_level !== 3'(m_level) || s_countdown !== 8'(m_cnt) ||
                          s_busy !== (m_level != 0) || s_turbo_avail !== 1'(m_avail))
                begin errors++; $display("FAIL rnd_sat_inst c=%0d got st=%0d lvl=%0d exp %0d/%0d", c, s_state, s_fan_level, m_state, m_level); end
        end
    endtask

    initial begin
        test_reset();
        test_level_run();
        test_turbo_timeout();
        test_drain();
        test_same_cycle();
        test_invalid_sel();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hood_fan_ctrl.md
Name: hood_fan_ctrl

Overview:
Parametrised range-hood fan controller: the next generation of the exhaust mode FSM. It adds N selectable normal speed levels and a timed turbo level, allowed once per cooking session, that can be entered from idle or from a running level. Menu from turbo triggers a timed drain phase at low speed. All timing runs off an external 1 Hz tick strobe. It sits between the debounced key/edge-detect front end and the fan driver, runtime display and 7-segment countdown display.

Parameters:
NUM_LEVELS, 3, number of normal fan levels (1..NUM_LEVELS), legal range 2..6
TURBO_SECS, 60, turbo duration in ticks, legal range 1..2^CNT_W-1
DRAIN_SECS, 60, drain duration in ticks, legal range 1..2^CNT_W-1
CNT_W, 8, countdown width
RUNTIME_W, 20, accumulated runtime width
LW, $clog2(NUM_LEVELS+2), derived width of fan_level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-clk-cycle strobe, once per second
menu_key  in  1  one-cycle key pulse
level_key  in  1  one-cycle key pulse, qualified by level_sel
level_sel  in  LW  requested level; only 1..NUM_LEVELS are accepted
turbo_key  in  1  one-cycle key pulse
fan_level  out  LW  0=off, 1..NUM_LEVELS=normal, NUM_LEVELS+1=turbo
state  out  2  00 IDLE, 01 RUN, 10 TURBO, 11 DRAIN
countdown  out  CNT_W  remaining seconds in TURBO/DRAIN, else 0
runtime  out  RUNTIME_W  ticks accumulated while fan_level!=0
busy  out  1  1 when fan_level!=0
turbo_avail  out  1  1 when turbo has not been used this session

Behaviour:
- Reset values (async): state=IDLE, fan_level=0, countdown=0, runtime=0, busy=0, turbo_avail=1. Reset mid-TURBO/DRAIN aborts immediately.
- All outputs are registered. A key pulse at edge k is visible at edge k+1. No combinational input-to-output path.
- Key priority within one cycle: menu_key > turbo_key > level_key.
- IDLE:
  - level_key with valid level_sel -> RUN at level_sel.
  - turbo_key with turbo_avail -> TURBO, countdown=TURBO_SECS, turbo_avail<=0.
  - menu_key is ignored.
- RUN:
  - menu_key -> IDLE.
  - turbo_key with turbo_avail -> TURBO (countdown load as above).
  - level_key with valid level_sel changes level and stays in RUN; the same level is a no-op.
- TURBO:
  - menu_key -> DRAIN, fan_level=1, countdown=DRAIN_SECS.
  - Each tick decrements countdown. A tick while countdown==1 -> RUN at level NUM_LEVELS, countdown=0.
  - level_key and turbo_key are ignored.
- DRAIN:
  - Each tick decrements countdown. A tick while countdown==1 -> IDLE.
  - All keys are ignored; the drain cannot be aborted except by rst.
- turbo_avail is cleared on TURBO entry and set again on every entry into IDLE (session end).
- Invalid level_sel (0 or >NUM_LEVELS) is ignored and causes no state change.
- Tick coincident with a transitioning key: the transition wins. The newly loaded countdown is not decremented that cycle.
- runtime increments on every tick where the pre-edge fan_level!=0, including DRAIN and the cycle of a key transition. It saturates at all-ones with no wrap.
- countdown never underflows. It is forced to 0 in IDLE/RUN.
- busy equals (next fan_level != 0), registered alongside fan_level.

Decomposition:
- Package hood_pkg: 2-bit state enum (IDLE/RUN/TURBO/DRAIN), state encodings, a helper function for the turbo level code (NUM_LEVELS+1).
- One sub-module, sec_countdown: a CNT_W loadable down-counter with inputs load, load_val, tick and outputs count and done. done is a one-cycle pulse on a tick while count==1. It is instantiated once and shared between TURBO and DRAIN.
- The runtime saturating counter stays inline.

Test Plan:
- Reset, then level_key with level_sel=2 -> next cycle state=RUN, fan_level=2, busy=1. Then 5 ticks -> runtime=5.
- In IDLE, turbo_key, then 60 ticks (defaults) -> countdown goes 60..1. On the 60th tick state=RUN, fan_level=3, countdown=0, turbo_avail=0. A further turbo_key is ignored.
- In TURBO with countdown=40, menu_key -> DRAIN, fan_level=1, countdown=60, busy=1. level_key is ignored. After 60 ticks -> IDLE, fan_level=0, turbo_avail=1.
- Same cycle: menu_key, turbo_key and level_key all asserted in RUN -> IDLE. Also tick + turbo_key in RUN -> countdown=60 (not 59), and runtime still increments.
- level_sel=0 and level_sel=NUM_LEVELS+1 with level_key in IDLE -> no change. Run with RUNTIME_W=4: after 20 ticks running, runtime saturates at 15.
- Assert rst during DRAIN with countdown=30 -> all outputs reach reset values asynchronously, before the next clk edge.
